cdb_broadcaster: RTL
====================

# cdb_broadcaster

Collects completed results from the functional units and drives the common data bus (CDB) that the reorder buffer and reservation stations snoop. Each functional unit pushes (ROB index, value) pairs into a private result FIFO; a round-robin arbiter grants up to `CDB_WIDTH` FIFOs per cycle and broadcasts the winners on registered CDB lanes. This block is the transmitting end of the CDB that the ROB consumes to mark entries finished.

## Interface
- `NUM_FU`, 6: number of functional-unit result ports.
- `CDB_WIDTH`, 4: number of CDB lanes; must equal ROB completion width.
- `FIFO_DEPTH`, 2: entries per FU result FIFO (power of two, ≥2).
- `IDX_W`, 4: ROB index width (16-entry ROB).
- `DATA_W`, 16: result value width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; discards all buffered results.
- `fu_valid[NUM_FU]`  in  1 each  FU presents a result.
- `fu_ready[NUM_FU]`  out  1 each  FIFO can accept; high when count < `FIFO_DEPTH`.
- `fu_rob_idx[NUM_FU]`  in  `IDX_W` each  ROB index of the result.
- `fu_value[NUM_FU]`  in  `DATA_W` each  result value.
- `cdb_valid[CDB_WIDTH]`  out  1 each  lane carries a result this cycle.
- `cdb_index[CDB_WIDTH]`  out  `IDX_W` each  ROB index on lane.
- `cdb_value[CDB_WIDTH]`  out  `DATA_W` each  value on lane.

## Operation
- Push: `fu_valid[f] && fu_ready[f]` writes into FIFO f at the edge. `fu_ready` depends only on the current count, never on a same-cycle pop. Valid while not ready is ignored (no error state); the FU holds.
- Arbitration each cycle: scan FUs from `rr_ptr` upward, modulo `NUM_FU`; grant the first `CDB_WIDTH` non-empty FIFOs, at most one pop per FU per cycle. Lane k receives the k-th grant in scan order; unused lanes have `cdb_valid` = 0, and their index and value hold their previous values.
- `rr_ptr` (width clog2(`NUM_FU`)) moves to (last granted FU + 1) mod `NUM_FU`; it is unchanged when there are no grants.
- Granted heads pop at the edge; CDB lane registers load at the same edge.
- Each FIFO is a circular buffer with read/write pointers and a count. Pointer wrap is modulo `FIFO_DEPTH`. A simultaneous push and pop leaves the count unchanged.
- `flush`: at the edge all FIFO counts and pointers go to 0 and all `cdb_valid` go to 0. Pushes and pops in the flush cycle are discarded. `rr_ptr` is kept.
- Reset (asynchronous, including mid-operation): FIFO counts and pointers = 0, `rr_ptr` = 0, `cdb_valid` = 0, `cdb_index` = 0, `cdb_value` = 0. As a result, `fu_ready` = 1 for all FUs during and after reset.
- No duplicate or ordering check on ROB indices. Order per FU is preserved; order across FUs follows arbitration.

## Timing
- Without bypass: result accepted at edge N, eligible for arbitration in cycle N+1, visible on CDB in cycle N+2 (latency 2).
- All outputs are registered except `fu_ready`, which is a combinational decode of the registered count.
- Peak throughput is `CDB_WIDTH` results per cycle; each FU sustains 1 per cycle when `FIFO_DEPTH` ≥ 2 and it is granted every cycle.

## Configuration
- `CDB_BYPASS_EN`:
  - Defined: an FU whose FIFO is empty and which is presenting `fu_valid` takes part in the same-cycle arbitration; its input is routed straight to the lane register (latency 1) and is not written into the FIFO. If it is not granted, it is pushed normally.
  - Undefined: latency is exactly 2 and there is no path from `fu_*` to `cdb_*`.

## Structure
- Package `ooo_pkg`: `ROB_IDX_W` = 4, `DATA_W` = 16, `CDB_WIDTH` = 4, and the packed struct `cdb_entry_t` {idx, value}, which is shared with the ROB and reservation stations.
- Sub-module `cdb_fu_fifo`: one instance per FU, holding the circular buffer, count, ready, and head outputs. Arbiter and lane registers live in the top module.

## Test plan
- Single result: after reset, FU2 pushes idx 5 / value 0x1234 at edge 0 → lane 0 shows valid, idx 5, 0x1234 in cycle 2 (cycle 1 when `CDB_BYPASS_EN` is defined); other lanes invalid.
- Oversubscription: all 6 FUs push one result at edge 0, `rr_ptr` = 0 → cycle 2 lanes 0–3 carry FU0–FU3; cycle 3 lanes 0–1 carry FU4–FU5; `rr_ptr` ends at 0.
- Fairness: FU0–FU5 push continuously for 12 cycles → grant counts per FU differ by at most 1, and no FU waits more than 2 arbitration cycles.
- Backpressure: FU1 pushes 3 back-to-back results while 4 other FUs saturate the lanes → `fu_ready[1]` drops after 2 accepted; all 3 values appear in push order with none lost or duplicated.
- Flush: FIFOs hold 5 results, assert `flush` one cycle → next cycle all `cdb_valid` = 0 and all `fu_ready` = 1; none of the 5 results ever appears.
- Async reset mid-stream: assert `rst` between edges while lanes are valid → `cdb_valid` clears immediately, without waiting for a clock edge; after release, a new push appears with the latency from the Timing section.

Source files
------------

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: CDB entry layout and CDB broadcaster sizing.
// The cdb_entry_t layout is common to the ROB, the reservation stations and the CDB.
package ooo_pkg;
    localparam int ROB_IDX_W  = 4;
    localparam int DATA_W     = 16;
    localparam int CDB_WIDTH  = 4;
    localparam int NUM_FU     = 6;
    localparam int FIFO_DEPTH = 2;
    localparam int FU_SEL_W   = $clog2(NUM_FU);
    localparam int FU_SUM_W   = FU_SEL_W + 1;

    typedef logic [FU_SEL_W-1:0] fu_sel_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] idx;
        logic [DATA_W-1:0]    value;
    } cdb_entry_t;

    // Reduce a sum below 2*NUM_FU to an FU number modulo NUM_FU.
    function automatic fu_sel_t fu_wrap(input logic [FU_SUM_W-1:0] sum);
        logic [FU_SUM_W-1:0] red;
        if (sum >= FU_SUM_W'(NUM_FU)) begin
            red = sum - FU_SUM_W'(NUM_FU);
        end else begin
            red = sum;
        end
        return red[FU_SEL_W-1:0];
    endfunction
endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU result ports and CDB lanes of the broadcaster; master is the FU/ROB side,
// slave is the broadcaster.
interface cdb_broadcaster_if;
    import ooo_pkg::*;

    logic [NUM_FU-1:0]                    fu_valid;
    logic [NUM_FU-1:0]                    fu_ready;
    logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob_idx;
    logic [NUM_FU-1:0][DATA_W-1:0]        fu_value;
    logic [CDB_WIDTH-1:0]                 cdb_valid;
    logic [CDB_WIDTH-1:0][ROB_IDX_W-1:0]  cdb_index;
    logic [CDB_WIDTH-1:0][DATA_W-1:0]     cdb_value;

    modport master (
        output fu_valid, fu_rob_idx, fu_value,
        input  fu_ready, cdb_valid, cdb_index, cdb_value
    );

    modport slave (
        input  fu_valid, fu_rob_idx, fu_value,
        output fu_ready, cdb_valid, cdb_index, cdb_value
    );
endinterface

// File: rtl/cdb_fu_fifo.sv
// Per-FU result FIFO: circular buffer with read/write pointers and an occupancy count.
// ready decodes only the registered count, so it never depends on a same-cycle pop.
module cdb_fu_fifo
    import ooo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output logic       ready,
    output logic       not_empty,
    output cdb_entry_t head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign ready     = (count_r < CNT_W'(DEPTH));
    assign not_empty = (count_r != {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push && ready;
    assign do_pop_s  = pop && not_empty;

    // Pointer and count update; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (do_pop_s && !do_push_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Entry storage; contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmitter: per-FU result FIFOs, round-robin grant of up to CDB_WIDTH FUs per
// cycle, registered CDB lanes. Define CDB_BYPASS_EN to let an empty FIFO's input reach a lane directly.
module cdb_broadcaster
    import ooo_pkg::*;
(
    input logic               clk,
    input logic               rst,
    input logic               flush,
    cdb_broadcaster_if.slave  bus
);
    localparam int LANE_CNT_W = $clog2(CDB_WIDTH + 1);

    logic [NUM_FU-1:0]        fifo_ne_s;
    logic [NUM_FU-1:0]        fifo_ready_s;
    logic [NUM_FU-1:0]        push_s;
    logic [NUM_FU-1:0]        pop_s;
    logic [NUM_FU-1:0]        cand_s;
    logic [NUM_FU-1:0]        grant_s;
    cdb_entry_t               fu_in_s  [NUM_FU];
    cdb_entry_t               head_s   [NUM_FU];
    cdb_entry_t               src_s    [NUM_FU];
    cdb_entry_t               lane_data_s [CDB_WIDTH];
    logic [CDB_WIDTH-1:0]     lane_use_s;
    logic [LANE_CNT_W-1:0]    lane_cnt_s;
    fu_sel_t                  sel_s;
    fu_sel_t                  last_s;
    fu_sel_t                  rr_next_s;
    logic                     take_s;
    logic                     any_grant_s;
    fu_sel_t                  rr_ptr_r;
    logic [CDB_WIDTH-1:0]     cdb_valid_r;
    cdb_entry_t               cdb_lane_r [CDB_WIDTH];

    for (genvar gf = 0; gf < NUM_FU; gf++) begin : g_fu
        assign fu_in_s[gf] = {bus.fu_rob_idx[gf], bus.fu_value[gf]};
`ifdef CDB_BYPASS_EN
        assign cand_s[gf] = fifo_ne_s[gf] || bus.fu_valid[gf];
        assign src_s[gf]  = fifo_ne_s[gf] ? head_s[gf] : fu_in_s[gf];
        // A bypassed result goes straight to its lane and skips the FIFO.
        assign push_s[gf] = bus.fu_valid[gf] && !(grant_s[gf] && !fifo_ne_s[gf]);
`else
        assign cand_s[gf] = fifo_ne_s[gf];
        assign src_s[gf]  = head_s[gf];
        assign push_s[gf] = bus.fu_valid[gf];
`endif
        assign pop_s[gf] = grant_s[gf] && fifo_ne_s[gf];

        cdb_fu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (push_s[gf]),
            .pop       (pop_s[gf]),
            .din       (fu_in_s[gf]),
            .ready     (fifo_ready_s[gf]),
            .not_empty (fifo_ne_s[gf]),
            .head      (head_s[gf])
        );
    end

    assign bus.fu_ready = fifo_ready_s;

    // Round-robin scan from rr_ptr; the k-th granted FU lands on lane k.
    always_comb begin
        grant_s     = {NUM_FU{1'b0}};
        lane_use_s  = {CDB_WIDTH{1'b0}};
        lane_cnt_s  = {LANE_CNT_W{1'b0}};
        last_s      = rr_ptr_r;
        any_grant_s = 1'b0;
        sel_s       = rr_ptr_r;
        take_s      = 1'b0;
        for (int k = 0; k < CDB_WIDTH; k++) begin
            lane_data_s[k] = {(ROB_IDX_W + DATA_W){1'b0}};
        end
        for (int i = 0; i < NUM_FU; i++) begin
            sel_s  = fu_wrap({1'b0, rr_ptr_r} + FU_SUM_W'(i));
            take_s = cand_s[sel_s] && (lane_cnt_s < LANE_CNT_W'(CDB_WIDTH));
            grant_s[sel_s] = take_s;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                lane_use_s[k]  = lane_use_s[k] | (take_s && (lane_cnt_s == LANE_CNT_W'(k)));
                lane_data_s[k] = (take_s && (lane_cnt_s == LANE_CNT_W'(k))) ? src_s[sel_s]
                                                                             : lane_data_s[k];
            end
            lane_cnt_s  = lane_cnt_s + (take_s ? LANE_CNT_W'(1) : LANE_CNT_W'(0));
            last_s      = take_s ? sel_s : last_s;
            any_grant_s = any_grant_s | take_s;
        end
        rr_next_s = any_grant_s ? fu_wrap({1'b0, last_s} + FU_SUM_W'(1)) : rr_ptr_r;
    end

    // Lane registers and round-robin pointer; idle lanes keep their last index/value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_r <= {CDB_WIDTH{1'b0}};
            rr_ptr_r    <= {FU_SEL_W{1'b0}};
            for (int k = 0; k < CDB_WIDTH; k++) begin
                cdb_lane_r[k] <= {(ROB_IDX_W + DATA_W){1'b0}};
            end
        end else if (flush) begin
            cdb_valid_r <= {CDB_WIDTH{1'b0}};
        end else begin
            cdb_valid_r <= lane_use_s;
            rr_ptr_r    <= rr_next_s;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (lane_use_s[k]) begin
                    cdb_lane_r[k] <= lane_data_s[k];
                end
            end
        end
    end

    assign bus.cdb_valid = cdb_valid_r;
    for (genvar gk = 0; gk < CDB_WIDTH; gk++) begin : g_lane
        assign bus.cdb_index[gk] = cdb_lane_r[gk].idx;
        assign bus.cdb_value[gk] = cdb_lane_r[gk].value;
    end
endmodule
